// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared types and constants for the instruction-fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int PC_STEP      = 4;
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_OVERFLOW = 1;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/ifetch_loader.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_loader
// Description : Boot-time program loader: accepts words, writes imem, flags
//               completion and capacity overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_loader #(
  parameter int ADDR_W     = 8,
  parameter int IMEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_load,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic              overflow
);
  import ifetch_pkg::*;

  localparam int CNT_W = $clog2(IMEM_WORDS) + 1;

  logic [CNT_W-1:0] r_count;
  logic             r_armed;
  logic             w_accept;
  logic             w_at_end;

  // r_armed keeps load_ready low until the first edge after reset release
  assign load_ready = r_armed & in_load;
  assign w_accept   = load_valid & load_ready;
  assign w_at_end   = (r_count == CNT_W'(IMEM_WORDS - 1));

  assign load_done  = w_accept & load_last;
  assign overflow   = w_accept & ~load_last & w_at_end;

  assign imem_we    = w_accept;
  assign imem_waddr = ADDR_W'({r_count, 2'b00});
  assign imem_wdata = w_accept ? load_data : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule : ifetch_loader
`default_nettype wire

// File: rtl/ifetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_sequencer
// Description : PC and imem sequencing: boot load, then fetch with stall,
//               redirect and halt. Optional macro IFETCH_REDIRECT_CNT_EN
//               enables the saturating redirect counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_sequencer #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = 'h00,
  parameter int                IMEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic [1:0]        state,
  output logic [1:0]        err,
  output logic [15:0]       redirect_count
);
  import ifetch_pkg::*;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [1:0]        r_err;
  logic              w_load_done;
  logic              w_overflow;
  logic              w_redirect_take;
  logic              w_misaligned;

  ifetch_loader #(
    .ADDR_W     (ADDR_W),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_loader (
    .clk        (clk),
    .reset      (reset),
    .in_load    (r_state == LOAD),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .load_done  (w_load_done),
    .overflow   (w_overflow)
  );

  assign w_redirect_take = (r_state == FETCH) & ~halt_req & redirect_valid;
  assign w_misaligned    = |redirect_target[1:0];

  // Next-PC priority in FETCH: halt > redirect > stall > sequential step
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      LOAD: begin
        w_pc_next = RESET_PC;
        if (w_load_done || w_overflow) begin
          w_state_next = FETCH;
        end
      end
      FETCH: begin
        if (halt_req) begin
          w_state_next = HALT;
        end else if (redirect_valid) begin
          w_pc_next = {redirect_target[ADDR_W-1:2], 2'b00};
        end else if (!stall) begin
          w_pc_next = r_pc + ADDR_W'(PC_STEP);
        end
      end
      HALT: begin
        w_state_next = HALT;
      end
      default: begin
        w_state_next = LOAD;
        w_pc_next    = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
      r_pc    <= RESET_PC;
      r_err   <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_redirect_take && w_misaligned) begin
        r_err[ERR_MISALIGN] <= 1'b1;
      end
      if (w_overflow) begin
        r_err[ERR_OVERFLOW] <= 1'b1;
      end
    end
  end

`ifdef IFETCH_REDIRECT_CNT_EN
  logic [15:0] r_redirect_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_redirect_count <= 16'h0;
    end else if (w_redirect_take && (r_redirect_count != 16'hFFFF)) begin
      r_redirect_count <= r_redirect_count + 16'h1;
    end
  end

  assign redirect_count = r_redirect_count;
`else
  assign redirect_count = 16'h0;
`endif

  assign pc          = r_pc;
  assign fetch_valid = (r_state == FETCH);
  assign state       = r_state;
  assign err         = r_err;

endmodule : ifetch_sequencer
`default_nettype wire

// File: tb/tb_ifetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_sequencer
// Description : Randomized self-checking bench for ifetch_sequencer against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_sequencer;

  localparam int ADDR_W     = 8;
  localparam int IMEM_WORDS = 64;
`ifdef IFETCH_REDIRECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              load_valid;
  logic              load_ready;
  logic [31:0]       load_data;
  logic              load_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              halt_req;
  logic [ADDR_W-1:0] pc;
  logic              fetch_valid;
  logic [1:0]        state;
  logic [1:0]        err;
  logic [15:0]       redirect_count;

  always #5 clk = ~clk;

  ifetch_sequencer #(
    .ADDR_W     (ADDR_W),
    .RESET_PC   (8'h00),
    .IMEM_WORDS (IMEM_WORDS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_data       (load_data),
    .load_last       (load_last),
    .imem_we         (imem_we),
    .imem_waddr      (imem_waddr),
    .imem_wdata      (imem_wdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .pc              (pc),
    .fetch_valid     (fetch_valid),
    .state           (state),
    .err             (err),
    .redirect_count  (redirect_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: 0=LOAD 1=FETCH 2=HALT
  int m_state, m_pc, m_err, m_cnt, m_lcount;
  bit m_armed;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    load_valid = 0; load_data = 0; load_last = 0;
    stall = 0; redirect_valid = 0; redirect_target = 0; halt_req = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #2;
    m_state = 0; m_pc = 0; m_err = 0; m_cnt = 0; m_lcount = 0; m_armed = 0;
    check_val("rst_state", 32'(state), 0);
    check_val("rst_pc", 32'(pc), 0);
    check_val("rst_fetch_valid", 32'(fetch_valid), 0);
    check_val("rst_load_ready", 32'(load_ready), 0);
    check_val("rst_imem_we", 32'(imem_we), 0);
    check_val("rst_imem_waddr", 32'(imem_waddr), 0);
    check_val("rst_imem_wdata", 32'(imem_wdata), 0);
    check_val("rst_err", 32'(err), 0);
    check_val("rst_redirect_count", 32'(redirect_count), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    m_armed = 1;
    #1;
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    bit exp_ready;
    bit exp_we;
    @(negedge clk);
    exp_ready = (m_state == 0) && m_armed;
    exp_we    = exp_ready && load_valid;
    check_val("load_ready", 32'(load_ready), 32'(exp_ready));
    check_val("imem_we", 32'(imem_we), 32'(exp_we));
    if (exp_we) begin
      check_val("imem_waddr", 32'(imem_waddr), (m_lcount * 4) % 256);
      check_val("imem_wdata", imem_wdata, load_data);
    end
    check_val("state", 32'(state), m_state);
    check_val("pc", 32'(pc), m_pc);
    check_val("fetch_valid", 32'(fetch_valid), 32'(m_state == 1));
    check_val("err", 32'(err), m_err);
    check_val("redirect_count", 32'(redirect_count), CNT_EN ? m_cnt : 0);
    @(posedge clk);
    if (m_state == 0) begin
      if (exp_we) begin
        m_lcount++;
        if (load_last) begin
          m_state = 1;
        end else if (m_lcount == IMEM_WORDS) begin
          m_err |= 2;
          m_state = 1;
        end
      end
      m_pc = 0;
    end else if (m_state == 1) begin
      if (halt_req) begin
        m_state = 2;
      end else if (redirect_valid) begin
        m_pc = int'(redirect_target) & 'hFC;
        if ((int'(redirect_target) & 3) != 0) m_err |= 1;
        if (m_cnt < 65535) m_cnt++;
      end else if (!stall) begin
        m_pc = (m_pc + 4) % 256;
      end
    end
    m_armed = 1;
    #1;
  endtask

  // Offer words with random gaps until the model leaves LOAD or the
  // requested number of words has been accepted (stop_at < 0: never stop).
  task automatic load_prog(input int n, input bit use_last, input int gap_pct, input int stop_at);
    int budget = 4 * n + 20;
    while (m_state == 0 && budget > 0 && (stop_at < 0 || m_lcount < stop_at)) begin
      load_valid = ($urandom_range(99) >= gap_pct);
      load_data  = $urandom;
      load_last  = load_valid ? (use_last && (m_lcount == n - 1)) : 1'($urandom);
      stall = 1'($urandom); redirect_valid = 1'($urandom);
      redirect_target = 8'($urandom); halt_req = 1'($urandom);
      cycle();
      budget--;
    end
    check_val("load_budget", 32'(budget > 0), 1);
    idle_inputs();
  endtask

  task automatic fetch_rand(input int n, input int halt_pct);
    for (int i = 0; i < n; i++) begin
      stall           = ($urandom_range(99) < 30);
      redirect_valid  = ($urandom_range(99) < 25);
      redirect_target = 8'($urandom);
      halt_req        = ($urandom_range(99) < halt_pct);
      load_valid      = 1'($urandom);
      load_data       = $urandom;
      load_last       = 1'($urandom);
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #3;
    apply_reset();

    // Three-word program with gaps, then sequential fetch
    load_prog(3, 1'b1, 40, -1);
    check_val("load3_words", 32'(m_lcount), 3);
    repeat (4) cycle();

    // Redirect beats stall; misaligned target flags err[0]
    stall = 1; redirect_valid = 1; redirect_target = 8'h22; cycle();
    redirect_valid = 0; cycle();
    stall = 0; redirect_valid = 1; redirect_target = 8'hFC; cycle();
    idle_inputs(); repeat (2) cycle();

    // Five clean redirects
    for (int i = 0; i < 5; i++) begin
      redirect_valid = 1; redirect_target = 8'($urandom) & 8'hFC; cycle();
    end
    idle_inputs();

    fetch_rand(80, 0);

    // Halt wins over redirect and stall, then everything ignored
    halt_req = 1; redirect_valid = 1; stall = 1; redirect_target = 8'h40; cycle();
    fetch_rand(10, 50);

    // Async reset in the middle of a load; reload restarts at address 0
    @(posedge clk); #3;
    apply_reset();
    load_prog(10, 1'b1, 20, 4);
    @(posedge clk); #3;
    apply_reset();
    load_prog(5, 1'b1, 30, -1);
    check_val("reload_words", 32'(m_lcount), 5);
    fetch_rand(20, 0);

    // Capacity overflow: no last word, extra words offered
    apply_reset();
    load_prog(IMEM_WORDS + 2, 1'b0, 0, -1);
    check_val("overflow_words", 32'(m_lcount), IMEM_WORDS);
    load_valid = 1; load_data = 32'hDEADBEEF;
    repeat (3) cycle();
    idle_inputs();
    fetch_rand(20, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ifetch_sequencer
`default_nettype wire
